// File: rtl/wb_cache.sv
// Direct-mapped write-back/write-allocate L1 cache: 8 lines x 16 B between a 16-bit CPU port and a 128-bit memory port.
// Latency: hit responds in the request cycle; clean miss = pmem latency + 1; dirty miss adds one writeback transaction.
// Backpressure: CPU holds its request until mem_resp; pmem requests stay stable until pmem_resp.
module wb_cache (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [15:0]   mem_address,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic [1:0]    mem_byte_enable,
   input  logic [15:0]   mem_wdata,
   output logic [15:0]   mem_rdata,
   output logic          mem_resp,
   output logic [15:0]   pmem_address,
   output logic          pmem_read,
   output logic          pmem_write,
   output logic [127:0]  pmem_wdata,
   input  logic [127:0]  pmem_rdata,
   input  logic          pmem_resp
);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, FILL = 2'd2} state_t;

   state_t        state_q, state_d;
   // Line address {tag, index} of the miss being serviced; latched so the
   // pmem address stays stable even if the CPU drops its request.
   logic [11:0]   line_q, line_d;
   logic [7:0]    valid_q, dirty_q;
   logic [8:0]    tag_q  [8];
   logic [127:0]  data_q [8];

   logic [2:0]    idx, lidx, word;
   logic [6:0]    word_bit;
   logic          req, hit;
   logic          hit_wr, wb_done, fill_done;
   logic          unused_addr_bit;

   assign idx             = mem_address[6:4];
   assign word            = mem_address[3:1];
   assign word_bit        = {word, 4'b0000};
   assign lidx            = line_q[2:0];
   assign req             = mem_read | mem_write;
   assign hit             = valid_q[idx] && (tag_q[idx] == mem_address[15:7]);
   assign unused_addr_bit = mem_address[0];

   // Next-state and output decode; every output is zero unless a state drives it.
   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      mem_resp     = 1'b0;
      mem_rdata    = 16'h0000;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0000;
      pmem_wdata   = 128'h0;
      hit_wr       = 1'b0;
      wb_done      = 1'b0;
      fill_done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  mem_resp = 1'b1;
                  // A simultaneous read and write is handled as a write.
                  if (mem_write) hit_wr = 1'b1;
                  else           mem_rdata = data_q[idx][word_bit +: 16];
               end else begin
                  line_d  = mem_address[15:4];
                  state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
               end
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[lidx], lidx, 4'b0000};
            pmem_wdata   = data_q[lidx];
            if (pmem_resp) begin
               wb_done = 1'b1;
               state_d = FILL;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {line_q, 4'b0000};
            if (pmem_resp) begin
               fill_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state and per-line valid/dirty bits; reset abandons any miss.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         line_q  <= 12'h000;
         valid_q <= 8'h00;
         dirty_q <= 8'h00;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         if (fill_done)              valid_q[lidx] <= 1'b1;
         if (hit_wr)                 dirty_q[idx]  <= 1'b1;
         if (wb_done || fill_done)   dirty_q[lidx] <= 1'b0;
      end
   end

   // Tag and data storage: whole-line install on fill, byte-merge on hit write.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_q[lidx] <= pmem_rdata;
         tag_q[lidx]  <= line_q[11:3];
      end else if (hit_wr) begin
         if (mem_byte_enable[0]) data_q[idx][word_bit +: 8]            <= mem_wdata[7:0];
         if (mem_byte_enable[1]) data_q[idx][(word_bit | 7'd8) +: 8]   <= mem_wdata[15:8];
      end
   end

endmodule

// File: tb/tb_wb_cache.sv
// Directed bench for wb_cache: table of CPU accesses against a latency-programmable memory model.
// Latency: every CPU access is bounded to 60 cycles.
// Backpressure: the memory model answers after pmem_lat cycles of a held request.
module tb_wb_cache;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [15:0]   mem_address;
   logic          mem_read, mem_write;
   logic [1:0]    mem_byte_enable;
   logic [15:0]   mem_wdata, mem_rdata;
   logic          mem_resp;
   logic [15:0]   pmem_address;
   logic          pmem_read, pmem_write;
   logic [127:0]  pmem_wdata, pmem_rdata;
   logic          pmem_resp;

   always #5 clk = ~clk;

   wb_cache dut (
      .clk(clk), .reset_n(reset_n),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Physical memory: untouched line L holds word w = L | w.
   logic [127:0] pmem_mem [logic [15:0]];

   function automatic logic [127:0] line_pattern(input logic [15:0] la);
      logic [127:0] r;
      for (int w = 0; w < 8; w++) r[w*16 +: 16] = {la[15:4], 1'b0, 3'(w)};
      return r;
   endfunction

   int            pmem_lat = 3;
   int            wait_cnt = 0;
   int            wb_cnt = 0, fill_cnt = 0, txn_no = 0, wb_no = 0, fill_no = 0;
   logic [15:0]   last_wb_addr = '0, last_fill_addr = '0;
   logic [127:0]  last_wb_dat = '0;

   // Memory responder: counts cycles of a held request and answers with a one-cycle pmem_resp.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (reset_n && (pmem_read || pmem_write)) begin
            wait_cnt++;
            if (wait_cnt >= pmem_lat) begin
               wait_cnt  = 0;
               pmem_resp = 1'b1;
               txn_no++;
               if (pmem_write) begin
                  pmem_mem[pmem_address] = pmem_wdata;
                  wb_cnt++; wb_no = txn_no;
                  last_wb_addr = pmem_address;
                  last_wb_dat  = pmem_wdata;
               end else begin
                  pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address]
                                                             : line_pattern(pmem_address);
                  fill_cnt++; fill_no = txn_no;
                  last_fill_addr = pmem_address;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Protocol monitor: read/write exclusive, and each request held stable until its response.
   int            viol = 0;
   logic          prev_act = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [15:0]   prev_addr = '0;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (pmem_read && pmem_write) viol++;
         if (prev_act && reset_n &&
             (pmem_read !== prev_rd || pmem_write !== prev_wr || pmem_address !== prev_addr)) viol++;
         prev_act  = reset_n && (pmem_read || pmem_write) && !pmem_resp;
         prev_rd   = pmem_read;
         prev_wr   = pmem_write;
         prev_addr = pmem_address;
      end
   end

   // One CPU access starting at a falling edge; returns data and cycles until mem_resp (-1 on timeout).
   task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, output logic [15:0] rdat, output int cyc);
      mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
      cyc  = -1;
      rdat = 16'h0000;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (mem_resp) begin
            cyc  = i;
            rdat = mem_rdata;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   typedef struct {
      logic          rd, wr;
      logic [15:0]   addr;
      logic [1:0]    be;
      logic [15:0]   wd;
      int            lat;
      logic [15:0]   exp_rdata;
      int            exp_cyc;
      int            exp_wb;
      logic [15:0]   exp_wb_addr;
      logic [127:0]  exp_wb_dat;
      int            exp_fill;
      logic [15:0]   exp_fill_addr;
   } vec_t;

   localparam logic [127:0] WB_A = 128'hAAAA_AAAA_AAAA_AAAA_AAEF_AAAA_AAAA_AAAA;
   localparam logic [127:0] WB_B = 128'h0057_0056_0055_0054_0053_5552_1234_0050;
   localparam logic [127:0] WB_C = 128'h00D7_00D6_00D5_00D4_00D3_00D2_CAFE_00D0;

   vec_t          vecs [19];
   logic [15:0]   rdat;
   int            cyc, wb0, f0;

   initial begin
      //          rd wr addr      be     wd        lat rdata     cyc wb wb_addr   wb_dat fill fill_addr
      vecs[0]  = '{1, 0, 16'h1234, 2'b00, 16'h0000, 3, 16'hAAAA, 4, 0, 16'h0000, 128'h0, 1, 16'h1230};
      vecs[1]  = '{1, 0, 16'h1234, 2'b00, 16'h0000, 3, 16'hAAAA, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[2]  = '{0, 1, 16'h1236, 2'b01, 16'hBEEF, 3, 16'h0000, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[3]  = '{1, 0, 16'h1236, 2'b00, 16'h0000, 3, 16'hAAEF, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[4]  = '{1, 0, 16'h1A36, 2'b00, 16'h0000, 3, 16'h1A33, 7, 1, 16'h1230, WB_A,   1, 16'h1A30};
      vecs[5]  = '{1, 0, 16'h1230, 2'b00, 16'h0000, 2, 16'hAAAA, 3, 0, 16'h0000, 128'h0, 1, 16'h1230};
      vecs[6]  = '{1, 0, 16'h1236, 2'b00, 16'h0000, 2, 16'hAAEF, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[7]  = '{0, 1, 16'h0052, 2'b11, 16'h1234, 1, 16'h0000, 2, 0, 16'h0000, 128'h0, 1, 16'h0050};
      vecs[8]  = '{1, 0, 16'h0052, 2'b00, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[9]  = '{0, 1, 16'h0054, 2'b10, 16'h5566, 1, 16'h0000, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[10] = '{1, 0, 16'h0054, 2'b00, 16'h0000, 1, 16'h5552, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[11] = '{0, 1, 16'h0056, 2'b00, 16'hFFFF, 1, 16'h0000, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[12] = '{1, 0, 16'h0056, 2'b00, 16'h0000, 1, 16'h0053, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[13] = '{1, 0, 16'h00D0, 2'b00, 16'h0000, 1, 16'h00D0, 3, 1, 16'h0050, WB_B,   1, 16'h00D0};
      vecs[14] = '{1, 1, 16'h00D2, 2'b11, 16'hCAFE, 1, 16'h0000, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[15] = '{1, 0, 16'h00D2, 2'b00, 16'h0000, 1, 16'hCAFE, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};
      vecs[16] = '{1, 0, 16'h01D0, 2'b00, 16'h0000, 1, 16'h01D0, 3, 1, 16'h00D0, WB_C,   1, 16'h01D0};
      vecs[17] = '{1, 0, 16'h00D0, 2'b00, 16'h0000, 1, 16'h00D0, 2, 0, 16'h0000, 128'h0, 1, 16'h00D0};
      vecs[18] = '{1, 0, 16'h00D2, 2'b00, 16'h0000, 1, 16'hCAFE, 0, 0, 16'h0000, 128'h0, 0, 16'h0000};

      pmem_mem[16'h1230] = {8{16'hAAAA}};
      reset_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_byte_enable = '0; mem_wdata = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_mem_resp",  128'(mem_resp),   128'h0);
      chk("idle_mem_rdata", 128'(mem_rdata),  128'h0);
      chk("idle_pmem_rw",   128'({pmem_read, pmem_write}), 128'h0);
      chk("idle_pmem_addr", 128'(pmem_address), 128'h0);
      chk("idle_pmem_wdat", pmem_wdata,       128'h0);
      @(negedge clk);

      for (int i = 0; i < 19; i++) begin
         pmem_lat = vecs[i].lat;
         wb0 = wb_cnt;
         f0  = fill_cnt;
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, rdat, cyc);
         chk($sformatf("v%0d_rdata", i), 128'(rdat), 128'(vecs[i].exp_rdata));
         chk($sformatf("v%0d_cycles", i), 128'(cyc), 128'(vecs[i].exp_cyc));
         chk($sformatf("v%0d_writebacks", i), 128'(wb_cnt - wb0), 128'(vecs[i].exp_wb));
         chk($sformatf("v%0d_fills", i), 128'(fill_cnt - f0), 128'(vecs[i].exp_fill));
         if (vecs[i].exp_wb != 0) begin
            chk($sformatf("v%0d_wb_addr", i), 128'(last_wb_addr), 128'(vecs[i].exp_wb_addr));
            chk($sformatf("v%0d_wb_data", i), last_wb_dat, vecs[i].exp_wb_dat);
            chk($sformatf("v%0d_wb_before_fill", i), 128'(fill_no > wb_no), 128'h1);
         end
         if (vecs[i].exp_fill != 0)
            chk($sformatf("v%0d_fill_addr", i), 128'(last_fill_addr), 128'(vecs[i].exp_fill_addr));
      end

      // Reset in the middle of a fill: pmem_read must drop at once and the line stays invalid.
      pmem_lat = 20;
      mem_read = 1'b1; mem_address = 16'h3344;
      repeat (3) @(negedge clk);
      #1;
      chk("midfill_pmem_read", 128'(pmem_read), 128'h1);
      chk("midfill_pmem_addr", 128'(pmem_address), 128'h3340);
      reset_n = 1'b0;
      #1;
      chk("reset_pmem_rw",   128'({pmem_read, pmem_write}), 128'h0);
      chk("reset_mem_resp",  128'(mem_resp), 128'h0);
      mem_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      pmem_lat = 2;
      f0 = fill_cnt; wb0 = wb_cnt;
      access(1'b1, 1'b0, 16'h3344, 2'b00, 16'h0000, rdat, cyc);
      chk("refetch_rdata",  128'(rdat), 128'h3342);
      chk("refetch_cycles", 128'(cyc), 128'd3);
      chk("refetch_fills",  128'(fill_cnt - f0), 128'd1);
      chk("refetch_addr",   128'(last_fill_addr), 128'h3340);
      f0 = fill_cnt;
      access(1'b1, 1'b0, 16'h1236, 2'b00, 16'h0000, rdat, cyc);
      chk("postreset_rdata",  128'(rdat), 128'hAAEF);
      chk("postreset_cycles", 128'(cyc), 128'd3);
      chk("postreset_fills",  128'(fill_cnt - f0), 128'd1);
      chk("postreset_no_wb",  128'(wb_cnt - wb0), 128'd0);

      chk("pmem_protocol", 128'(viol), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
